// File: rtl/pll_profile_sequencer.sv
// PLL reconfiguration sequencer: selects a profile ROM, reloads the scan
// chain, applies it and waits for stable lock, with timeouts and retries.
//
// Ports:
//   clock, reset            : clock, async active-low reset
//   want_to_reconfig        : request (rising edge accepted in IDLE/FAULT)
//   intended_rom            : requested profile index
//   main_reset_rom_address  : external ROM address reset (ORed into output)
//   busy, locked            : reconfig-circuit busy, PLL locked
//   mux_sel                 : ROM mux select
//   write_from_rom          : 1-cycle scan-chain load pulse
//   reconfig                : 1-cycle scan-chain apply pulse
//   reset_rom_address       : internal 1-cycle pulse OR external reset
//   current_state           : FSM state encoding
//   active_rom, active_valid: last successfully locked profile
//   ready, done, reject     : idle flag, success/skip pulse, range reject
//   error, retry_count      : sticky fault flag, retries used
module pll_profile_sequencer #(
  parameter int ROM_COUNT    = 4,
  parameter int SEL_W        = 2,
  parameter int BUSY_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16,
  parameter int MAX_RETRY    = 2,
  parameter int CNT_W        = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             want_to_reconfig,
  input  logic [SEL_W-1:0] intended_rom,
  input  logic             main_reset_rom_address,
  input  logic             busy,
  input  logic             locked,
  output logic [SEL_W-1:0] mux_sel,
  output logic             write_from_rom,
  output logic             reconfig,
  output logic             reset_rom_address,
  output logic [2:0]       current_state,
  output logic [SEL_W-1:0] active_rom,
  output logic             active_valid,
  output logic             ready,
  output logic             done,
  output logic             reject,
  output logic             error,
  output logic [1:0]       retry_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_LOAD  = 3'd2,
    S_WLOAD = 3'd3,
    S_RCFG  = 3'd4,
    S_WRCFG = 3'd5,
    S_WLOCK = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [SEL_W:0] ROM_LIM =
    (SEL_W+1)'(ROM_COUNT);
  localparam logic [CNT_W-1:0] BUSY_LAST =
    CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST =
    CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  state_t           state_q, state_d;
  logic             want_q;
  logic [SEL_W-1:0] mux_q, mux_d;
  logic             wfr_q, wfr_d;
  logic             rcfg_q, rcfg_d;
  logic             rra_q, rra_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic             seen_q, seen_d;
  logic [SEL_W-1:0] arom_q, arom_d;
  logic             avld_q, avld_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             err_q, err_d;
  logic [1:0]       retry_q, retry_d;

  logic             req_edge;
  logic             oor;
  logic             same;
  logic [CNT_W-1:0] timer_inc;
  logic [CNT_W-1:0] stab_inc;

  assign req_edge = want_to_reconfig & ~want_q;
  assign oor = {1'b0, intended_rom} >= ROM_LIM;
  assign same = (intended_rom == arom_q)
              & avld_q & locked;
  // Counters saturate so a stalled wait can never wrap.
  assign timer_inc = (&timer_q) ? timer_q
                   : timer_q + 1'b1;
  assign stab_inc = (&stab_q) ? stab_q
                  : stab_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mux_d   = mux_q;
    timer_d = timer_q;
    stab_d  = stab_q;
    seen_d  = seen_q;
    arom_d  = arom_q;
    avld_d  = avld_q;
    err_d   = err_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_FAULT: begin
        if (req_edge) begin
          if (oor) begin
            rej_d = 1'b1;
          end else if (same) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            mux_d   = intended_rom;
            err_d   = 1'b0;
            retry_d = 2'd0;
            state_d = S_RST;
          end
        end
      end
      S_RST: state_d = S_LOAD;
      S_LOAD: begin
        timer_d = '0;
        seen_d  = 1'b0;
        state_d = S_WLOAD;
      end
      S_WLOAD, S_WRCFG: begin
        timer_d = timer_inc;
        if (busy) seen_d = 1'b1;
        if (seen_q && !busy) begin
          if (state_q == S_WLOAD) begin
            state_d = S_RCFG;
          end else begin
            timer_d = '0;
            stab_d  = '0;
            state_d = S_WLOCK;
          end
        end else if (timer_q == BUSY_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_RCFG: begin
        timer_d = '0;
        seen_d  = 1'b0;
        state_d = S_WRCFG;
      end
      S_WLOCK: begin
        timer_d = timer_inc;
        stab_d  = locked ? stab_inc : '0;
        // Lock success takes priority over a coincident timeout.
        if (locked && stab_q == STAB_LAST) begin
          arom_d  = mux_q;
          avld_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == LOCK_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_RST;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FAULT) begin
      err_d  = 1'b1;
      avld_d = 1'b0;
    end
    rra_d   = (state_d == S_RST);
    wfr_d   = (state_d == S_LOAD);
    rcfg_d  = (state_d == S_RCFG);
    ready_d = (state_d == S_IDLE)
            | (state_d == S_FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      want_q  <= 1'b0;
      mux_q   <= '0;
      wfr_q   <= 1'b0;
      rcfg_q  <= 1'b0;
      rra_q   <= 1'b0;
      timer_q <= '0;
      stab_q  <= '0;
      seen_q  <= 1'b0;
      arom_q  <= '0;
      avld_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= 2'd0;
    end else begin
      state_q <= state_d;
      want_q  <= want_to_reconfig;
      mux_q   <= mux_d;
      wfr_q   <= wfr_d;
      rcfg_q  <= rcfg_d;
      rra_q   <= rra_d;
      timer_q <= timer_d;
      stab_q  <= stab_d;
      seen_q  <= seen_d;
      arom_q  <= arom_d;
      avld_q  <= avld_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  assign mux_sel           = mux_q;
  assign write_from_rom    = wfr_q;
  assign reconfig          = rcfg_q;
  assign reset_rom_address = rra_q
                           | main_reset_rom_address;
  assign current_state     = state_q;
  assign active_rom        = arom_q;
  assign active_valid      = avld_q;
  assign ready             = ready_q;
  assign done              = done_q;
  assign reject            = rej_q;
  assign error             = err_q;
  assign retry_count       = retry_q;

endmodule

// File: tb/tb_pll_profile_sequencer.sv
// Directed bench for pll_profile_sequencer with small timeouts.
// Busy responder models the reconfig circuit; locked is driven inline.
module tb_pll_profile_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       want = 1'b0;
  logic [1:0] rom = 2'd0;
  logic       main_rra = 1'b0;
  logic       busy = 1'b0;
  logic       locked = 1'b0;
  logic [1:0] mux_sel;
  logic       wfr;
  logic       rcfg;
  logic       rra;
  logic [2:0] st;
  logic [1:0] arom;
  logic       avld;
  logic       ready;
  logic       done;
  logic       reject;
  logic       error;
  logic [1:0] retry;

  bit auto_busy = 1'b1;
  int passed = 0;
  int total = 0;
  int wfr_n = 0;
  int rcf_n = 0;
  int done_n = 0;
  int rsta_n = 0;
  int w0, r0, d0, a0;
  bit hit;

  pll_profile_sequencer #(
    .ROM_COUNT(3), .SEL_W(2),
    .BUSY_TIMEOUT(16), .LOCK_TIMEOUT(40),
    .LOCK_STABLE(4), .MAX_RETRY(2),
    .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .want_to_reconfig(want),
    .intended_rom(rom),
    .main_reset_rom_address(main_rra),
    .busy(busy), .locked(locked),
    .mux_sel(mux_sel),
    .write_from_rom(wfr),
    .reconfig(rcfg),
    .reset_rom_address(rra),
    .current_state(st),
    .active_rom(arom),
    .active_valid(avld),
    .ready(ready), .done(done),
    .reject(reject), .error(error),
    .retry_count(retry)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wfr) wfr_n++;
    if (rcfg) rcf_n++;
    if (done) done_n++;
    if (st == 3'd1) rsta_n++;
  end

  // Busy goes high right after each load/apply pulse for 3 edges.
  always begin
    @(posedge clock);
    #1;
    if (auto_busy && (wfr || rcfg)) begin
      busy = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_st"}, 32'(st), 0);
    chk({tag, "_mux"}, 32'(mux_sel), 0);
    chk({tag, "_wfr"}, 32'(wfr), 0);
    chk({tag, "_rcfg"}, 32'(rcfg), 0);
    chk({tag, "_rra"}, 32'(rra), 0);
    chk({tag, "_arom"}, 32'(arom), 0);
    chk({tag, "_avld"}, 32'(avld), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rej"}, 32'(reject), 0);
    chk({tag, "_err"}, 32'(error), 0);
    chk({tag, "_retry"}, 32'(retry), 0);
  endtask

  initial begin
    repeat (3) step();
    chk_zero("rst");
    reset = 1'b1;
    step();
    chk("idle_ready", 32'(ready), 1);

    // Full sequence to profile 2.
    w0 = wfr_n; r0 = rcf_n; d0 = done_n;
    want = 1'b1; rom = 2'd2;
    step();
    want = 1'b0;
    chk("t1_s1", 32'(st), 1);
    chk("t1_rra", 32'(rra), 1);
    chk("t1_mux", 32'(mux_sel), 2);
    chk("t1_busyflag", 32'(ready), 0);
    step();
    chk("t1_s2", 32'(st), 2);
    chk("t1_wfr", 32'(wfr), 1);
    chk("t1_rra0", 32'(rra), 0);
    step();
    chk("t1_s3", 32'(st), 3);
    chk("t1_wfr0", 32'(wfr), 0);
    step(); step();
    chk("t1_s3b", 32'(st), 3);
    step();
    chk("t1_s4", 32'(st), 4);
    chk("t1_rcfg", 32'(rcfg), 1);
    step();
    chk("t1_s5", 32'(st), 5);
    chk("t1_rcfg0", 32'(rcfg), 0);
    step(); step();
    chk("t1_s5b", 32'(st), 5);
    step();
    chk("t1_s6", 32'(st), 6);
    repeat (6) step();
    locked = 1'b1;
    repeat (3) step();
    chk("t1_s6b", 32'(st), 6);
    chk("t1_nodone", 32'(done), 0);
    step();
    chk("t1_s0", 32'(st), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_arom", 32'(arom), 2);
    chk("t1_avld", 32'(avld), 1);
    chk("t1_ready", 32'(ready), 1);
    step();
    chk("t1_done0", 32'(done), 0);
    chk("t1_wfr_n", 32'(wfr_n - w0), 1);
    chk("t1_rcf_n", 32'(rcf_n - r0), 1);
    chk("t1_done_n", 32'(done_n - d0), 1);

    // External address reset passes straight through.
    main_rra = 1'b1;
    #1;
    chk("ext_rra", 32'(rra), 1);
    main_rra = 1'b0;
    #1;
    chk("ext_rra0", 32'(rra), 0);

    // Same profile while locked: skip.
    w0 = wfr_n; r0 = rcf_n;
    want = 1'b1; rom = 2'd2;
    step();
    want = 1'b0;
    chk("t2_done", 32'(done), 1);
    chk("t2_s0", 32'(st), 0);
    step();
    chk("t2_done0", 32'(done), 0);
    chk("t2_wfr_n", 32'(wfr_n - w0), 0);
    chk("t2_rcf_n", 32'(rcf_n - r0), 0);

    // Out-of-range index.
    d0 = done_n;
    want = 1'b1; rom = 2'd3;
    step();
    want = 1'b0;
    chk("t3_rej", 32'(reject), 1);
    chk("t3_s0", 32'(st), 0);
    chk("t3_ready", 32'(ready), 1);
    chk("t3_mux", 32'(mux_sel), 2);
    step();
    chk("t3_rej0", 32'(reject), 0);
    chk("t3_pulses", 32'(wfr_n - w0 + rcf_n - r0), 0);
    chk("t3_done_n", 32'(done_n - d0), 0);

    // Never locks: two retries then fault.
    locked = 1'b0;
    a0 = rsta_n;
    want = 1'b1; rom = 2'd1;
    step();
    want = 1'b0;
    chk("t4_s1", 32'(st), 1);
    chk("t4_mux", 32'(mux_sel), 1);
    chk("t4_retry0", 32'(retry), 0);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (st == 3'd7) hit = 1'b1;
    end
    chk("t4_reach_fault", 32'(hit), 1);
    chk("t4_rst_entries", 32'(rsta_n - a0), 3);
    chk("t4_retry", 32'(retry), 2);
    chk("t4_err", 32'(error), 1);
    chk("t4_avld", 32'(avld), 0);
    chk("t4_ready", 32'(ready), 1);

    // New valid request out of fault.
    want = 1'b1; rom = 2'd0;
    step();
    want = 1'b0;
    chk("t4r_s1", 32'(st), 1);
    chk("t4r_err", 32'(error), 0);
    chk("t4r_retry", 32'(retry), 0);
    chk("t4r_mux", 32'(mux_sel), 0);

    // Edges mid-sequence are dropped.
    step();
    chk("t6_s2", 32'(st), 2);
    want = 1'b1; rom = 2'd2;
    step();
    want = 1'b0;
    chk("t6_s3", 32'(st), 3);
    chk("t6_mux", 32'(mux_sel), 0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (st == 3'd5) hit = 1'b1;
    end
    chk("t6_reach_wrcfg", 32'(hit), 1);
    want = 1'b1; rom = 2'd1;
    step();
    chk("t6_s5", 32'(st), 5);
    chk("t6_mux2", 32'(mux_sel), 0);

    // Asynchronous reset mid-wait.
    reset = 1'b0;
    #1;
    chk_zero("t6r");
    want = 1'b0;
    step();
    reset = 1'b1;

    // Busy never asserts: load wait times out.
    auto_busy = 1'b0;
    repeat (5) step();
    chk("t5_busy_idle", 32'(busy), 0);
    want = 1'b1; rom = 2'd1;
    step();
    want = 1'b0;
    chk("t5_s1", 32'(st), 1);
    step();
    step();
    chk("t5_s3", 32'(st), 3);
    repeat (15) step();
    chk("t5_s3_last", 32'(st), 3);
    step();
    chk("t5_s7", 32'(st), 7);
    chk("t5_err", 32'(error), 1);
    chk("t5_avld", 32'(avld), 0);

    // Reject in fault keeps the state and error.
    want = 1'b1; rom = 2'd3;
    step();
    want = 1'b0;
    chk("t5_rej", 32'(reject), 1);
    chk("t5_s7b", 32'(st), 7);
    chk("t5_err2", 32'(error), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
